// File: rtl/l2_assoc_cache_pkg.sv
// Shared definitions for the L2 set-associative cache: FSM states and
// parameter-derived widths used by the top and the LRU selector.
package l2_assoc_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WBACK,
    FILL
  } l2_state_e;

  function automatic bit ways_legal(input int unsigned ways);
    return (ways == 1) || (ways == 2) || (ways == 4);
  endfunction

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned sets);
    return addr_w - $clog2(sets);
  endfunction

  // A direct-mapped cache still carries a 1-bit way index that is always 0.
  function automatic int unsigned way_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/l2_assoc_cache_lru_sel.sv
// Per-set age-based LRU state: picks the victim way for the indexed set and
// ages the set when a way is touched.
module l2_lru_sel
  import l2_assoc_cache_pkg::*;
#(
  parameter int unsigned SETS = 16,
  parameter int unsigned WAYS = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [idx_width(SETS)-1:0]    set_idx,
  input  logic [WAYS-1:0]               valid_vec,
  input  logic                          touch,
  input  logic [way_width(WAYS)-1:0]    touch_way,
  output logic [way_width(WAYS)-1:0]    victim
);

  localparam int unsigned WAY_W = way_width(WAYS);

  logic [WAY_W-1:0] lru_way;
  logic             found;

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid_vec[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) victim = lru_way;
  end

  if (WAYS == 1) begin : g_dm
    logic unused_dm;
    assign unused_dm = ^{clk, reset_n, set_idx, touch, touch_way};
    assign lru_way   = '0;
  end else begin : g_lru
    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] touched_age;
    logic [WAY_W-1:0] best_age;

    assign touched_age = age_q[set_idx][touch_way];

    always_comb begin
      lru_way  = '0;
      best_age = age_q[set_idx][0];
      for (int unsigned w = 1; w < WAYS; w++) begin
        if (age_q[set_idx][w] > best_age) begin
          best_age = age_q[set_idx][w];
          lru_way  = WAY_W'(w);
        end
      end
    end

    // Ages clear to all-zero, so equal ages are treated as younger too; once
    // every way of a set has been touched the ages form a strict recency order.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned s = 0; s < SETS; s++)
          for (int unsigned w = 0; w < WAYS; w++)
            age_q[s][w] <= '0;
      end else if (touch) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way)
            age_q[set_idx][w] <= '0;
          else if (age_q[set_idx][w] <= touched_age && age_q[set_idx][w] != '1)
            age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/l2_assoc_cache.sv
// Write-back, write-allocate set-associative L2 line cache with zero-wait
// hits and a single outstanding memory transaction (writeback then fill).
module l2_assoc_cache
  import l2_assoc_cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              L2_read,
  input  logic              L2_write,
  input  logic [ADDR_W-1:0] L2_addr,
  input  logic [LINE_W-1:0] L2_wdata,
  output logic              L2_ready,
  output logic [LINE_W-1:0] L2_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       miss_count
);

  localparam int unsigned IDX_W = idx_width(SETS);
  localparam int unsigned TAG_W = tag_width(ADDR_W, SETS);
  localparam int unsigned WAY_W = way_width(WAYS);

  if (!ways_legal(WAYS)) begin : g_bad_ways
    $error("l2_assoc_cache: WAYS must be 1, 2 or 4");
  end
  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("l2_assoc_cache: SETS must be a power of two, at least 2");
  end

  l2_state_e state_q, state_d;

  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              req_valid;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAYS-1:0]   valid_vec;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  victim_q;
  logic              victim_dirty;
  logic              miss_start;

  assign idx       = L2_addr[IDX_W-1:0];
  assign tag       = L2_addr[ADDR_W-1:IDX_W];
  assign req_valid = L2_read ^ L2_write;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    valid_vec = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      valid_vec[w] = valid_q[idx][w];
      if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign L2_ready     = (state_q == IDLE) && req_valid && hit;
  assign L2_rdata     = (L2_ready && L2_read) ? data_q[idx][hit_way] : '0;
  assign miss_start   = (state_q == IDLE) && req_valid && !hit;
  assign victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];

  l2_lru_sel #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_idx   (idx),
    .valid_vec (valid_vec),
    .touch     (L2_ready),
    .touch_way (hit_way),
    .victim    (victim)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_start) state_d = victim_dirty ? WBACK : FILL;
      WBACK:   if (mem_ready)  state_d = FILL;
      FILL:    if (mem_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      miss_count <= '0;
      victim_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (miss_start) begin
          victim_q <= victim;
          if (miss_count != '1) miss_count <= miss_count + 32'd1;
          if (victim_dirty) begin
            mem_write <= 1'b1;
            mem_addr  <= {tag_q[idx][victim], idx};
            mem_wdata <= data_q[idx][victim];
          end else begin
            mem_read  <= 1'b1;
            mem_addr  <= L2_addr;
          end
        end
        WBACK: if (mem_ready) begin
          mem_write <= 1'b0;
          mem_read  <= 1'b1;
          mem_addr  <= L2_addr;
        end
        FILL: if (mem_ready) mem_read <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
        end
      end
    end else begin
      if (L2_ready && L2_write) begin
        data_q[idx][hit_way]  <= L2_wdata;
        dirty_q[idx][hit_way] <= 1'b1;
      end
      if (state_q == WBACK && mem_ready) dirty_q[idx][victim_q] <= 1'b0;
      if (state_q == FILL && mem_ready) begin
        data_q[idx][victim_q]  <= mem_rdata;
        tag_q[idx][victim_q]   <= tag;
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_l2_assoc_cache.sv
// Randomized self-checking bench for l2_assoc_cache: a 2-way/16-set instance
// and a direct-mapped 32-set instance checked against a recency-stamp model.
module tb_l2_assoc_cache;

  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          l2_read, l2_write, mem_ready;
  logic [AW-1:0] l2_addr;
  logic [LW-1:0] l2_wdata, mem_rdata;

  logic          a_ready, a_mem_read, a_mem_write, d_ready, d_mem_read, d_mem_write;
  logic [LW-1:0] a_rdata, a_mem_wdata, d_rdata, d_mem_wdata;
  logic [AW-1:0] a_mem_addr, d_mem_addr;
  logic [31:0]   a_miss, d_miss;

  logic          sel;
  logic          s_ready, s_mem_read, s_mem_write;
  logic [LW-1:0] s_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;
  logic [31:0]   s_miss;

  always #5 clk = ~clk;

  l2_assoc_cache #(.ADDR_W(AW), .LINE_W(LW), .SETS(16), .WAYS(2)) dut (
    .clk(clk), .reset_n(reset_n), .L2_read(l2_read), .L2_write(l2_write),
    .L2_addr(l2_addr), .L2_wdata(l2_wdata), .L2_ready(a_ready), .L2_rdata(a_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .miss_count(a_miss));

  l2_assoc_cache #(.ADDR_W(AW), .LINE_W(LW), .SETS(32), .WAYS(1)) dut_dm (
    .clk(clk), .reset_n(reset_n), .L2_read(l2_read), .L2_write(l2_write),
    .L2_addr(l2_addr), .L2_wdata(l2_wdata), .L2_ready(d_ready), .L2_rdata(d_rdata),
    .mem_read(d_mem_read), .mem_write(d_mem_write), .mem_addr(d_mem_addr),
    .mem_wdata(d_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .miss_count(d_miss));

  assign s_ready     = sel ? d_ready     : a_ready;
  assign s_rdata     = sel ? d_rdata     : a_rdata;
  assign s_mem_read  = sel ? d_mem_read  : a_mem_read;
  assign s_mem_write = sel ? d_mem_write : a_mem_write;
  assign s_mem_addr  = sel ? d_mem_addr  : a_mem_addr;
  assign s_mem_wdata = sel ? d_mem_wdata : a_mem_wdata;
  assign s_miss      = sel ? d_miss      : a_miss;

  int n_checks = 0;
  int n_errors = 0;
  int viol     = 0;

  // Reference model: line contents plus a recency stamp per way.
  int            m_sets, m_ways, stamp_ctr;
  bit            m_valid [32][4];
  bit            m_dirty [32][4];
  logic [AW-1:0] m_line  [32][4];
  logic [LW-1:0] m_data  [32][4];
  int            m_stamp [32][4];
  int unsigned   m_miss;
  logic [LW-1:0] tb_mem  [logic [AW-1:0]];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];

  bit            x_wr [4], o_wr [4];
  logic [AW-1:0] x_addr [4], o_addr [4];
  logic [LW-1:0] x_data [4], o_data [4];
  int            x_n, o_n;

  function automatic logic [LW-1:0] line_pat(input logic [AW-1:0] a);
    logic [31:0] a32;
    a32 = {4'h0, a};
    return {a32 ^ 32'h5A5A_5A5A, a32 * 32'd3, ~a32, a32 + 32'h1000_0001};
  endfunction

  function automatic logic [LW-1:0] tb_get(input logic [AW-1:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : line_pat(a);
  endfunction

  function automatic logic [LW-1:0] ref_get(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : line_pat(a);
  endfunction

  task automatic model_reset(input int sets, input int ways);
    m_sets = sets; m_ways = ways; m_miss = 0; stamp_ctr = 0;
    for (int s = 0; s < 32; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_line[s][w] = '0;
        m_data[s][w] = '0; m_stamp[s][w] = 0;
      end
  endtask

  task automatic model_access(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wd,
                              input int wl, input int fl,
                              output logic [LW-1:0] exp_rd, output int exp_cyc);
    int idx, w, v;
    idx = int'(addr) % m_sets;
    x_n = 0; w = -1; exp_cyc = 0;
    for (int k = 0; k < m_ways; k++)
      if (m_valid[idx][k] && m_line[idx][k] == addr) w = k;
    if (w < 0) begin
      v = -1;
      for (int k = 0; k < m_ways; k++)
        if (v < 0 && !m_valid[idx][k]) v = k;
      if (v < 0) begin
        v = 0;
        for (int k = 1; k < m_ways; k++)
          if (m_stamp[idx][k] < m_stamp[idx][v]) v = k;
      end
      if (m_valid[idx][v] && m_dirty[idx][v]) begin
        x_wr[x_n] = 1; x_addr[x_n] = m_line[idx][v]; x_data[x_n] = m_data[idx][v]; x_n++;
        ref_mem[m_line[idx][v]] = m_data[idx][v];
        exp_cyc = wl;
      end
      x_wr[x_n] = 0; x_addr[x_n] = addr; x_data[x_n] = '0; x_n++;
      m_valid[idx][v] = 1; m_dirty[idx][v] = 0; m_line[idx][v] = addr;
      m_data[idx][v] = ref_get(addr);
      exp_cyc += fl + 1;
      if (m_miss != 32'hFFFF_FFFF) m_miss++;
      w = v;
    end
    stamp_ctr++;
    m_stamp[idx][w] = stamp_ctr;
    if (wr) begin
      m_data[idx][w] = wd; m_dirty[idx][w] = 1; exp_rd = '0;
    end else begin
      exp_rd = m_data[idx][w];
    end
  endtask

  // Presents one request at a negedge and plays memory until L2_ready; cyc=-1 on timeout.
  task automatic dut_access(input bit rd, input bit wr, input logic [AW-1:0] addr,
                            input logic [LW-1:0] wd, input int wl, input int fl,
                            output int cyc, output logic [LW-1:0] rdata);
    bit op_act, op_wr, done;
    logic [AW-1:0] op_addr;
    logic [LW-1:0] op_data;
    int waitc;
    o_n = 0;
    for (int k = 0; k < 4; k++) begin o_wr[k] = 0; o_addr[k] = '1; o_data[k] = '0; end
    op_act = 0; op_wr = 0; op_addr = '0; op_data = '0; waitc = 0; done = 0;
    rdata = '0; cyc = -1;
    l2_read = rd; l2_write = wr; l2_addr = addr; l2_wdata = wd;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (s_mem_read && s_mem_write) viol++;
      if (s_ready) begin
        done = 1; cyc = c; rdata = s_rdata;
      end else if (s_mem_read || s_mem_write) begin
        if (!op_act) begin
          op_act = 1; op_wr = s_mem_write; op_addr = s_mem_addr; op_data = s_mem_wdata; waitc = 0;
          if (o_n < 4) begin o_wr[o_n] = op_wr; o_addr[o_n] = op_addr; o_data[o_n] = op_data; end
          o_n++;
        end else if (s_mem_write !== op_wr || s_mem_addr !== op_addr ||
                     (op_wr && s_mem_wdata !== op_data)) begin
          viol++;
        end
        waitc++;
        if (waitc >= (op_wr ? wl : fl)) begin
          mem_ready = 1'b1;
          if (op_wr) tb_mem[op_addr] = op_data;
          else       mem_rdata = tb_get(op_addr);
          op_act = 0;
        end
      end
      @(posedge clk); @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
    l2_read = 1'b0; l2_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; l2_read = 1'b0; l2_write = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; l2_read = 1'b0; l2_write = 1'b0; mem_ready = 1'b0;
    l2_addr = '0; l2_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (s_mem_read !== 1'b0) begin n_errors++; $display("FAIL reset_mem_read got %b want 0", s_mem_read); end
    n_checks++; if (s_mem_write !== 1'b0) begin n_errors++; $display("FAIL reset_mem_write got %b want 0", s_mem_write); end
    n_checks++; if (s_mem_addr !== '0) begin n_errors++; $display("FAIL reset_mem_addr got %h want 0", s_mem_addr); end
    n_checks++; if (s_mem_wdata !== '0) begin n_errors++; $display("FAIL reset_mem_wdata got %h want 0", s_mem_wdata); end
    n_checks++; if (s_miss !== 32'd0) begin n_errors++; $display("FAIL reset_miss_count got %0d want 0", s_miss); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL idle_no_req_ready got %b want 0", s_ready); end
    n_checks++; if (s_rdata !== '0) begin n_errors++; $display("FAIL idle_no_req_rdata got %h want 0", s_rdata); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [LW-1:0] rd, er, b, c;
    int cyc, ec;
    b = {4{32'hBBBB_0B0B}};
    c = {4{32'hCCCC_0C0C}};
    model_access(0, 28'h10, '0, 1, 2, er, ec);
    dut_access(1, 0, 28'h10, '0, 1, 2, cyc, rd);
    n_checks++; if (o_n != 1 || o_wr[0] !== 1'b0 || o_addr[0] !== 28'h10) begin n_errors++;
      $display("FAIL first_miss_mem got n=%0d wr=%b addr=%h want n=1 read addr 0000010", o_n, o_wr[0], o_addr[0]); end
    n_checks++; if (cyc != 3) begin n_errors++; $display("FAIL first_miss_latency got %0d want 3", cyc); end
    n_checks++; if (rd !== line_pat(28'h10)) begin n_errors++; $display("FAIL first_miss_rdata got %h want %h", rd, line_pat(28'h10)); end
    n_checks++; if (s_miss !== 32'd1) begin n_errors++; $display("FAIL first_miss_count got %0d want 1", s_miss); end

    model_access(1, 28'h10, b, 1, 1, er, ec);
    dut_access(0, 1, 28'h10, b, 1, 1, cyc, rd);
    n_checks++; if (cyc != 0 || o_n != 0) begin n_errors++; $display("FAIL write_hit got cyc=%0d memops=%0d want 0 0", cyc, o_n); end
    n_checks++; if (rd !== '0) begin n_errors++; $display("FAIL write_hit_rdata got %h want 0", rd); end

    model_access(1, 28'h110, c, 1, 2, er, ec);
    dut_access(0, 1, 28'h110, c, 1, 2, cyc, rd);
    n_checks++; if (o_n != 1 || o_wr[0] !== 1'b0 || o_addr[0] !== 28'h110) begin n_errors++;
      $display("FAIL second_way_fill got n=%0d wr=%b addr=%h want n=1 read addr 0000110", o_n, o_wr[0], o_addr[0]); end
    n_checks++; if (cyc != 3) begin n_errors++; $display("FAIL second_way_latency got %0d want 3", cyc); end

    model_access(0, 28'h10, '0, 1, 1, er, ec);
    dut_access(1, 0, 28'h10, '0, 1, 1, cyc, rd);
    n_checks++; if (cyc != 0 || rd !== b) begin n_errors++; $display("FAIL read_b got cyc=%0d data=%h want 0 %h", cyc, rd, b); end
    model_access(0, 28'h110, '0, 1, 1, er, ec);
    dut_access(1, 0, 28'h110, '0, 1, 1, cyc, rd);
    n_checks++; if (cyc != 0 || rd !== c) begin n_errors++; $display("FAIL read_c got cyc=%0d data=%h want 0 %h", cyc, rd, c); end

    model_access(0, 28'h210, '0, 2, 3, er, ec);
    dut_access(1, 0, 28'h210, '0, 2, 3, cyc, rd);
    n_checks++; if (o_n != 2 || o_wr[0] !== 1'b1 || o_addr[0] !== 28'h10 || o_data[0] !== b) begin n_errors++;
      $display("FAIL dirty_evict_wb got n=%0d wr=%b addr=%h data=%h want write 0000010 %h", o_n, o_wr[0], o_addr[0], o_data[0], b); end
    n_checks++; if (o_wr[1] !== 1'b0 || o_addr[1] !== 28'h210) begin n_errors++;
      $display("FAIL dirty_evict_fill got wr=%b addr=%h want read 0000210", o_wr[1], o_addr[1]); end
    n_checks++; if (cyc != 6) begin n_errors++; $display("FAIL dirty_evict_latency got %0d want 6", cyc); end
    n_checks++; if (rd !== line_pat(28'h210) || s_miss !== 32'd3) begin n_errors++;
      $display("FAIL dirty_evict_result got data=%h miss=%0d want %h 3", rd, s_miss, line_pat(28'h210)); end
  endtask

  task automatic test_both_high();
    logic [31:0] prev;
    prev = s_miss;
    l2_read = 1'b1; l2_write = 1'b1; l2_addr = 28'h0ABC_DE5;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (s_ready !== 1'b0 || s_mem_read !== 1'b0 || s_mem_write !== 1'b0) begin n_errors++;
        $display("FAIL both_high cyc%0d got ready=%b mr=%b mw=%b want 0 0 0", c, s_ready, s_mem_read, s_mem_write); end
      @(posedge clk); @(negedge clk);
    end
    l2_read = 1'b0; l2_write = 1'b0;
    n_checks++; if (s_miss !== prev) begin n_errors++; $display("FAIL both_high_miss got %0d want %0d", s_miss, prev); end
  endtask

  task automatic test_random(input int n, input string name);
    logic [LW-1:0] rd, er, wd;
    logic [AW-1:0] addr;
    int cyc, ec, wl, fl;
    bit wr;
    viol = 0;
    for (int i = 0; i < n; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 4) * m_sets + $urandom_range(0, m_sets - 1));
      addr[AW-1] = 1'($urandom_range(0, 1));
      wd   = {$urandom, $urandom, $urandom, $urandom};
      wl   = $urandom_range(1, 3);
      fl   = $urandom_range(1, 3);
      model_access(wr, addr, wd, wl, fl, er, ec);
      dut_access(!wr, wr, addr, wd, wl, fl, cyc, rd);
      n_checks++; if (cyc != ec) begin n_errors++; $display("FAIL %s%0d latency got %0d want %0d", name, i, cyc, ec); end
      n_checks++; if (rd !== er) begin n_errors++; $display("FAIL %s%0d rdata got %h want %h", name, i, rd, er); end
      n_checks++; if (o_n != x_n) begin n_errors++; $display("FAIL %s%0d memops got %0d want %0d", name, i, o_n, x_n); end
      for (int k = 0; k < x_n && k < o_n; k++) begin
        n_checks++;
        if (o_wr[k] !== x_wr[k] || o_addr[k] !== x_addr[k] || (x_wr[k] && o_data[k] !== x_data[k])) begin
          n_errors++;
          $display("FAIL %s%0d memop%0d got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                   name, i, k, o_wr[k], o_addr[k], o_data[k], x_wr[k], x_addr[k], x_data[k]);
        end
      end
      n_checks++; if (s_miss !== m_miss) begin n_errors++; $display("FAIL %s%0d miss_count got %0d want %0d", name, i, s_miss, m_miss); end
    end
    n_checks++; if (viol != 0) begin n_errors++; $display("FAIL %s mem_protocol got %0d violations want 0", name, viol); end
  endtask

  task automatic test_reset_mid_fill();
    logic [LW-1:0] rd, er;
    int cyc, ec;
    bit seen;
    seen = 0;
    l2_read = 1'b1; l2_addr = 28'h3F7;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); @(negedge clk); #1;
      if (s_mem_read) seen = 1;
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL midfill_start got no mem_read want mem_read"); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (s_mem_read !== 1'b0 || s_mem_addr !== '0 || s_miss !== 32'd0) begin n_errors++;
      $display("FAIL midfill_async_reset got mr=%b addr=%h miss=%0d want 0 0 0", s_mem_read, s_mem_addr, s_miss); end
    l2_read = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset(16, 2);
    model_access(0, 28'h10, '0, 1, 2, er, ec);
    dut_access(1, 0, 28'h10, '0, 1, 2, cyc, rd);
    n_checks++; if (o_n != 1 || o_addr[0] !== 28'h10 || cyc != 3) begin n_errors++;
      $display("FAIL after_reset_miss got n=%0d addr=%h cyc=%0d want 1 0000010 3", o_n, o_addr[0], cyc); end
    n_checks++; if (rd !== er || s_miss !== 32'd1) begin n_errors++;
      $display("FAIL after_reset_data got %h miss=%0d want %h 1", rd, s_miss, er); end
  endtask

  task automatic test_direct_mapped();
    logic [LW-1:0] rd, er;
    int cyc, ec;
    sel = 1'b1;
    do_reset();
    model_reset(32, 1);
    model_access(0, 28'h20, '0, 1, 1, er, ec);
    dut_access(1, 0, 28'h20, '0, 1, 1, cyc, rd);
    n_checks++; if (o_n != 1 || o_addr[0] !== 28'h20 || rd !== er) begin n_errors++;
      $display("FAIL dm_first got n=%0d addr=%h data=%h want 1 0000020 %h", o_n, o_addr[0], rd, er); end
    model_access(0, 28'h40, '0, 1, 1, er, ec);
    dut_access(1, 0, 28'h40, '0, 1, 1, cyc, rd);
    n_checks++; if (o_n != 1 || o_wr[0] !== 1'b0 || o_addr[0] !== 28'h40 || cyc != 2) begin n_errors++;
      $display("FAIL dm_conflict got n=%0d wr=%b addr=%h cyc=%0d want 1 read 0000040 2", o_n, o_wr[0], o_addr[0], cyc); end
    n_checks++; if (s_miss !== 32'd2) begin n_errors++; $display("FAIL dm_miss_count got %0d want 2", s_miss); end
    test_random(80, "dm_rand");
  endtask

  initial begin
    sel = 1'b0;
    model_reset(16, 2);
    test_reset();
    test_directed();
    test_both_high();
    test_random(250, "rand");
    test_reset_mid_fill();
    test_direct_mapped();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
